// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Optional hit/miss counters are enabled with the ICACHE_PERF_EN macro.
package icache_pkg;

  localparam int XLEN                 = 32;
  localparam int ICACHE_IDX_WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    ICACHE_STATE_IDLE = 2'd0,
    ICACHE_STATE_REQ  = 2'd1,
    ICACHE_STATE_WAIT = 2'd2
  } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache.
// It has one combinational read port, one synchronous write port and a synchronous clear of the valid bits.
module icache_array
  import icache_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_WIDTH_DEF,
  parameter int TAG_W = XLEN - IDX_W - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [XLEN-1:0]  o_rd_data,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [XLEN-1:0]  i_wr_data
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [DEPTH];
  logic [XLEN-1:0]  r_data [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: a clear valid bit masks them.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between the fetcher and the memory controller.
// Define ICACHE_PERF_EN to add the ic_hit_cnt and ic_miss_cnt lookup counters.
module icache
  import icache_pkg::*;
#(
  parameter int ICACHE_IDX_WIDTH = ICACHE_IDX_WIDTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            fet_ic_enable,
  input  logic [XLEN-1:0] fet_ic_pc,
  output logic            ic_fet_ready,
  output logic [XLEN-1:0] ic_fet_inst,
  output logic [XLEN-1:0] ic_fet_pc,
  output logic            ic_fet_busy,
  output logic            ic_mem_enable,
  output logic [XLEN-1:0] ic_mem_pc,
  input  logic            mem_fet_busy,
  input  logic            mem_inst_ready,
  input  logic [XLEN-1:0] mem_inst,
`ifdef ICACHE_PERF_EN
  input  logic [XLEN-1:0] mem_inst_addr,
  output logic [XLEN-1:0] ic_hit_cnt,
  output logic [XLEN-1:0] ic_miss_cnt
`else
  input  logic [XLEN-1:0] mem_inst_addr
`endif
);

  localparam int TAG_W = XLEN - ICACHE_IDX_WIDTH - 1;

  icache_state_e r_state, w_state_nxt;

  logic [XLEN-1:0]             r_miss_pc, w_miss_pc_nxt;
  logic                        r_ready, w_ready_nxt;
  logic [XLEN-1:0]             r_inst, w_inst_nxt;
  logic [XLEN-1:0]             r_pc, w_pc_nxt;
  logic                        r_busy;
  logic                        r_mem_enable;
  logic [XLEN-1:0]             r_mem_pc;

  logic                        w_rd_valid;
  logic [TAG_W-1:0]            w_rd_tag;
  logic [XLEN-1:0]             w_rd_data;
  logic                        w_hit;
  logic                        w_fill;
  logic                        w_lookup;
  logic                        w_resp_match;

  icache_array #(
    .IDX_W (ICACHE_IDX_WIDTH),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (fet_ic_pc[ICACHE_IDX_WIDTH:1]),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_fill && rdy),
    .i_wr_idx   (r_miss_pc[ICACHE_IDX_WIDTH:1]),
    .i_wr_tag   (r_miss_pc[XLEN-1:ICACHE_IDX_WIDTH+1]),
    .i_wr_data  (mem_inst)
  );

  assign w_hit        = w_rd_valid && (w_rd_tag == fet_ic_pc[XLEN-1:ICACHE_IDX_WIDTH+1]);
  assign w_resp_match = mem_inst_ready && (mem_inst_addr == r_miss_pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ICACHE_STATE_IDLE;
    end else if (rdy) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_miss_pc_nxt = r_miss_pc;
    w_ready_nxt   = 1'b0;
    w_inst_nxt    = r_inst;
    w_pc_nxt      = r_pc;
    w_fill        = 1'b0;
    w_lookup      = 1'b0;
    case (r_state)
      ICACHE_STATE_IDLE: begin
        if (fet_ic_enable) begin
          w_lookup = 1'b1;
          if (w_hit) begin
            w_ready_nxt = 1'b1;
            w_inst_nxt  = w_rd_data;
            w_pc_nxt    = fet_ic_pc;
          end else begin
            w_miss_pc_nxt = fet_ic_pc;
            w_state_nxt   = ICACHE_STATE_REQ;
          end
        end
      end
      ICACHE_STATE_REQ: begin
        if (mem_fet_busy) begin
          w_state_nxt = ICACHE_STATE_WAIT;
        end
      end
      ICACHE_STATE_WAIT: begin
        // Address compare rejects stale responses held over from earlier requests.
        if (w_resp_match) begin
          w_fill      = 1'b1;
          w_ready_nxt = 1'b1;
          w_inst_nxt  = mem_inst;
          w_pc_nxt    = r_miss_pc;
          w_state_nxt = ICACHE_STATE_IDLE;
        end else if (!mem_fet_busy) begin
          w_state_nxt = ICACHE_STATE_REQ;
        end
      end
      default: w_state_nxt = ICACHE_STATE_IDLE;
    endcase
    if (flush) begin
      w_state_nxt   = ICACHE_STATE_IDLE;
      w_miss_pc_nxt = r_miss_pc;
      w_ready_nxt   = 1'b0;
      w_inst_nxt    = r_inst;
      w_pc_nxt      = r_pc;
      w_fill        = 1'b0;
      w_lookup      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_miss_pc    <= '0;
      r_ready      <= 1'b0;
      r_inst       <= '0;
      r_pc         <= '0;
      r_busy       <= 1'b0;
      r_mem_enable <= 1'b0;
      r_mem_pc     <= '0;
    end else if (rdy) begin
      r_miss_pc    <= w_miss_pc_nxt;
      r_ready      <= w_ready_nxt;
      r_inst       <= w_inst_nxt;
      r_pc         <= w_pc_nxt;
      r_busy       <= (w_state_nxt != ICACHE_STATE_IDLE);
      r_mem_enable <= (w_state_nxt == ICACHE_STATE_REQ);
      r_mem_pc     <= w_miss_pc_nxt;
    end
  end

  assign ic_fet_ready  = r_ready;
  assign ic_fet_inst   = r_inst;
  assign ic_fet_pc     = r_pc;
  assign ic_fet_busy   = r_busy;
  assign ic_mem_enable = r_mem_enable;
  assign ic_mem_pc     = r_mem_pc;

`ifdef ICACHE_PERF_EN
  logic [XLEN-1:0] r_hit_cnt;
  logic [XLEN-1:0] r_miss_cnt;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (rdy && w_lookup) begin
      if (w_hit) begin
        r_hit_cnt <= r_hit_cnt + 1'b1;
      end else begin
        r_miss_cnt <= r_miss_cnt + 1'b1;
      end
    end
  end

  assign ic_hit_cnt  = r_hit_cnt;
  assign ic_miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: directed fetch/miss/flush sequences with a decoupled pulse monitor.
// Counter checks are compiled in when ICACHE_PERF_EN is defined.
module tb_icache;
  import icache_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rdy = 1'b1;
  logic            flush = 1'b0;
  logic            fet_ic_enable = 1'b0;
  logic [XLEN-1:0] fet_ic_pc = '0;
  logic            ic_fet_ready;
  logic [XLEN-1:0] ic_fet_inst;
  logic [XLEN-1:0] ic_fet_pc;
  logic            ic_fet_busy;
  logic            ic_mem_enable;
  logic [XLEN-1:0] ic_mem_pc;
  logic            mem_fet_busy = 1'b0;
  logic            mem_inst_ready = 1'b0;
  logic [XLEN-1:0] mem_inst = '0;
  logic [XLEN-1:0] mem_inst_addr = '0;
`ifdef ICACHE_PERF_EN
  logic [XLEN-1:0] ic_hit_cnt;
  logic [XLEN-1:0] ic_miss_cnt;
  logic [XLEN-1:0] hit0, miss0;
`endif

  typedef struct {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  icache dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .flush          (flush),
    .fet_ic_enable  (fet_ic_enable),
    .fet_ic_pc      (fet_ic_pc),
    .ic_fet_ready   (ic_fet_ready),
    .ic_fet_inst    (ic_fet_inst),
    .ic_fet_pc      (ic_fet_pc),
    .ic_fet_busy    (ic_fet_busy),
    .ic_mem_enable  (ic_mem_enable),
    .ic_mem_pc      (ic_mem_pc),
    .mem_fet_busy   (mem_fet_busy),
    .mem_inst_ready (mem_inst_ready),
    .mem_inst       (mem_inst),
`ifdef ICACHE_PERF_EN
    .mem_inst_addr  (mem_inst_addr),
    .ic_hit_cnt     (ic_hit_cnt),
    .ic_miss_cnt    (ic_miss_cnt)
`else
    .mem_inst_addr  (mem_inst_addr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ic_fet_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got inst %h pc %h expected no pulse", ic_fet_inst, ic_fet_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_inst", ic_fet_inst, e.inst);
        chk("pulse_pc", ic_fet_pc, e.pc);
      end
    end
  end

  task automatic request(input logic [XLEN-1:0] pc);
    fet_ic_enable = 1'b1;
    fet_ic_pc     = pc;
    tick();
    fet_ic_enable = 1'b0;
  endtask

  task automatic do_miss(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst);
    exp_t e;
    request(pc);
    chk("miss_mem_enable", ic_mem_enable, 1);
    chk("miss_mem_pc", ic_mem_pc, pc);
    chk("miss_busy", ic_fet_busy, 1);
    mem_fet_busy = 1'b1;
    tick();
    chk("wait_mem_enable", ic_mem_enable, 0);
    mem_inst_ready = 1'b1;
    mem_inst       = inst;
    mem_inst_addr  = pc;
    e.inst = inst;
    e.pc   = pc;
    q.push_back(e);
    tick();
    mem_inst_ready = 1'b0;
    mem_fet_busy   = 1'b0;
    chk("fill_ready", ic_fet_ready, 1);
    chk("fill_busy", ic_fet_busy, 0);
  endtask

  task automatic expect_hit(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst);
    exp_t e;
    e.inst = inst;
    e.pc   = pc;
    q.push_back(e);
    request(pc);
    chk("hit_ready", ic_fet_ready, 1);
    chk("hit_no_mem", ic_mem_enable, 0);
    chk("hit_busy", ic_fet_busy, 0);
  endtask

  initial begin
    exp_t e;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_ready", ic_fet_ready, 0);
    chk("rst_inst", ic_fet_inst, 0);
    chk("rst_pc", ic_fet_pc, 0);
    chk("rst_busy", ic_fet_busy, 0);
    chk("rst_mem_enable", ic_mem_enable, 0);
    chk("rst_mem_pc", ic_mem_pc, 0);
`ifdef ICACHE_PERF_EN
    chk("rst_hit_cnt", ic_hit_cnt, 0);
    chk("rst_miss_cnt", ic_miss_cnt, 0);
`endif

    // Cold miss then hit
    do_miss(32'h0000_1000, 32'h0000_0013);
    expect_hit(32'h0000_1000, 32'h0000_0013);

    // Halfword PC, index conflict and eviction
    do_miss(32'h0000_1002, 32'h0000_4505);
    expect_hit(32'h0000_1002, 32'h0000_4505);
    do_miss(32'h0000_1082, 32'hABCD_0001);
    expect_hit(32'h0000_1082, 32'hABCD_0001);
    do_miss(32'h0000_1002, 32'h0000_4505);
    expect_hit(32'h0000_1000, 32'h0000_0013);

    // Flush while waiting, late response ignored
    request(32'h0000_2000);
    mem_fet_busy = 1'b1;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", ic_fet_busy, 0);
    chk("flush_mem_enable", ic_mem_enable, 0);
    mem_fet_busy   = 1'b0;
    mem_inst_ready = 1'b1;
    mem_inst       = 32'h0000_0093;
    mem_inst_addr  = 32'h0000_2000;
    repeat (2) tick();
    chk("late_resp_ready", ic_fet_ready, 0);
    mem_inst_ready = 1'b0;
    do_miss(32'h0000_2000, 32'h0000_0093);

    // Flush together with a request that would hit
    flush         = 1'b1;
    fet_ic_enable = 1'b1;
    fet_ic_pc     = 32'h0000_1000;
    tick();
    flush         = 1'b0;
    fet_ic_enable = 1'b0;
    chk("flush_req_ready", ic_fet_ready, 0);
    chk("flush_req_busy", ic_fet_busy, 0);

    // rdy low freezes the lookup
    tick();
    rdy           = 1'b0;
    fet_ic_enable = 1'b1;
    fet_ic_pc     = 32'h0000_1000;
    tick();
    fet_ic_enable = 1'b0;
    rdy           = 1'b1;
    chk("frozen_ready", ic_fet_ready, 0);
    tick();

`ifdef ICACHE_PERF_EN
    hit0  = ic_hit_cnt;
    miss0 = ic_miss_cnt;
`endif

    // Controller drops the fetch: re-issue
    request(32'h0000_4000);
    chk("drop_mem_enable", ic_mem_enable, 1);
    mem_fet_busy = 1'b1;
    repeat (5) tick();
    chk("drop_wait_enable", ic_mem_enable, 0);
    chk("drop_wait_busy", ic_fet_busy, 1);
    mem_fet_busy = 1'b0;
    tick();
    chk("reissue_enable", ic_mem_enable, 1);
    chk("reissue_pc", ic_mem_pc, 32'h0000_4000);
    mem_fet_busy = 1'b1;
    tick();
    mem_inst_ready = 1'b1;
    mem_inst       = 32'h0000_0193;
    mem_inst_addr  = 32'h0000_4000;
    e.inst = 32'h0000_0193;
    e.pc   = 32'h0000_4000;
    q.push_back(e);
    tick();
    mem_inst_ready = 1'b0;
    mem_fet_busy   = 1'b0;

    // Stale ready with the wrong address while waiting
    request(32'h0000_3000);
    mem_fet_busy = 1'b1;
    tick();
    mem_inst_ready = 1'b1;
    mem_inst       = 32'hDEAD_BEEF;
    mem_inst_addr  = 32'h0000_1000;
    repeat (3) tick();
    chk("stale_ready", ic_fet_ready, 0);
    chk("stale_busy", ic_fet_busy, 1);
    mem_inst      = 32'h0000_0113;
    mem_inst_addr = 32'h0000_3000;
    e.inst = 32'h0000_0113;
    e.pc   = 32'h0000_3000;
    q.push_back(e);
    tick();
    mem_inst_ready = 1'b0;
    mem_fet_busy   = 1'b0;
    chk("stale_fill_busy", ic_fet_busy, 0);
    expect_hit(32'h0000_3000, 32'h0000_0113);
`ifdef ICACHE_PERF_EN
    chk("perf_hit_delta", ic_hit_cnt - hit0, 1);
    chk("perf_miss_delta", ic_miss_cnt - miss0, 2);
`endif

    // Reset mid-miss invalidates everything
    request(32'h0000_5000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", ic_fet_busy, 0);
    chk("midrst_enable", ic_mem_enable, 0);
    do_miss(32'h0000_1000, 32'h0000_0013);

    repeat (3) tick();
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
